// File: rtl/pong_game_ctrl.sv
// Pong game controller: start-button sync, game FSM, score/lives bookkeeping, and ball/paddle tick generation.
// Optional pause on a start press during play: define PONG_PAUSE_EN.
module pong_game_ctrl #(
    parameter int unsigned BALL_BASE    = 80000,
    parameter int unsigned BALL_STEP    = 500,
    parameter int unsigned BALL_MIN     = 20000,
    parameter int unsigned PADDLE_BASE  = 120000,
    parameter int unsigned PADDLE_STEP  = 250,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       CLK_50,
    input  logic       RESET,
    input  logic       start_n,
    input  logic       frame_start,
    input  logic       ball_hit,
    input  logic       ball_miss,
    output logic       ball_tick,
    output logic       paddle_tick,
    output logic       ball_reset,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [1:0] game_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int unsigned FRAME_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);
    localparam int unsigned BALL_P0 = (BALL_BASE > BALL_MIN) ? BALL_BASE : BALL_MIN;

    state_e             state_q, state_d;
    logic [7:0]         score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [2:0]         sync_q;
    logic [31:0]        ball_cnt_q, ball_cnt_d, ball_per_q, ball_per_d;
    logic [31:0]        pad_cnt_q, pad_cnt_d, pad_per_q, pad_per_d;
    logic               ball_tick_q, ball_tick_d;
    logic               pad_tick_q, pad_tick_d;
    logic               ball_reset_q, ball_reset_d;
`ifdef PONG_PAUSE_EN
    logic               paused_q, paused_d;
`endif

    logic        press_c;
    logic [31:0] ball_dec_c, ball_sub_c, ball_per_c, pad_per_c;
    logic        act_c, freeze_c, ball_run_c, pad_run_c;

    // sync_q[2] holds the previous synchronized level for falling-edge detection
    assign press_c = sync_q[2] & ~sync_q[1];

    // Score-dependent periods; the ball period clamps at BALL_MIN without wrapping
    always_comb begin
        ball_dec_c = BALL_STEP * 32'(score_q);
        ball_sub_c = (ball_dec_c >= BALL_BASE) ? 32'd0 : (BALL_BASE - ball_dec_c);
        ball_per_c = (ball_sub_c > BALL_MIN) ? ball_sub_c : BALL_MIN;
        pad_per_c  = PADDLE_BASE + PADDLE_STEP * 32'(score_q);
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        lives_d  = lives_q;
        frame_d  = frame_q;
        act_c    = 1'b1;
        freeze_c = 1'b0;
`ifdef PONG_PAUSE_EN
        paused_d = paused_q;
`endif
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press_c) begin
                    state_d = ST_SERVE;
                    score_d = 8'd0;
                    lives_d = 2'(LIVES);
                    frame_d = '0;
                end
            end
            ST_SERVE: begin
                if (frame_start) begin
                    if (frame_q == FRAME_W'(SERVE_FRAMES - 1)) begin
                        state_d = ST_PLAY;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + FRAME_W'(1);
                    end
                end
            end
            ST_PLAY: begin
`ifdef PONG_PAUSE_EN
                if (press_c) begin
                    paused_d = ~paused_q;
                    act_c    = 1'b0;
                end
                if (paused_q) begin
                    act_c = 1'b0;
                end
`endif
                if (act_c && ball_miss) begin
                    lives_d = lives_q - 2'd1;
                    state_d = (lives_q == 2'd1) ? ST_OVER : ST_SERVE;
                    frame_d = '0;
                end else if (act_c && ball_hit && score_q != 8'hFF) begin
                    score_d = score_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef PONG_PAUSE_EN
        freeze_c = paused_q | paused_d;
`endif

        // Counters advance only when running both before and after this edge
        ball_run_c = (state_q == ST_PLAY) && (state_d == ST_PLAY) && !freeze_c;
        pad_run_c  = (state_q == ST_SERVE || state_q == ST_PLAY) &&
                     (state_d == ST_SERVE || state_d == ST_PLAY) && !freeze_c;

        ball_cnt_d = ball_cnt_q;
        ball_per_d = ball_per_q;
        if (state_d != ST_PLAY) begin
            ball_cnt_d = 32'd0;
            ball_per_d = ball_per_c;
        end else if (ball_run_c) begin
            if (ball_cnt_q == ball_per_q - 32'd1) begin
                ball_cnt_d = 32'd0;
                ball_per_d = ball_per_c;
            end else begin
                ball_cnt_d = ball_cnt_q + 32'd1;
            end
        end

        pad_cnt_d = pad_cnt_q;
        pad_per_d = pad_per_q;
        if (state_d != ST_SERVE && state_d != ST_PLAY) begin
            pad_cnt_d = 32'd0;
            pad_per_d = pad_per_c;
        end else if (pad_run_c) begin
            if (pad_cnt_q == pad_per_q - 32'd1) begin
                pad_cnt_d = 32'd0;
                pad_per_d = pad_per_c;
            end else begin
                pad_cnt_d = pad_cnt_q + 32'd1;
            end
        end

        ball_tick_d  = ball_run_c && (ball_cnt_d == ball_per_d - 32'd1);
        pad_tick_d   = pad_run_c && (pad_cnt_d == pad_per_d - 32'd1);
        ball_reset_d = (state_d != ST_PLAY);
    end

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            score_q      <= 8'd0;
            lives_q      <= 2'd0;
            frame_q      <= '0;
            sync_q       <= 3'd0;
            ball_cnt_q   <= 32'd0;
            ball_per_q   <= BALL_P0;
            pad_cnt_q    <= 32'd0;
            pad_per_q    <= PADDLE_BASE;
            ball_tick_q  <= 1'b0;
            pad_tick_q   <= 1'b0;
            ball_reset_q <= 1'b1;
`ifdef PONG_PAUSE_EN
            paused_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            frame_q      <= frame_d;
            sync_q       <= {sync_q[1:0], start_n};
            ball_cnt_q   <= ball_cnt_d;
            ball_per_q   <= ball_per_d;
            pad_cnt_q    <= pad_cnt_d;
            pad_per_q    <= pad_per_d;
            ball_tick_q  <= ball_tick_d;
            pad_tick_q   <= pad_tick_d;
            ball_reset_q <= ball_reset_d;
`ifdef PONG_PAUSE_EN
            paused_q     <= paused_d;
`endif
        end
    end

    assign ball_tick   = ball_tick_q;
    assign paddle_tick = pad_tick_q;
    assign ball_reset  = ball_reset_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign game_state  = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized + directed bench for pong_game_ctrl with a per-cycle behavioural reference model.
module tb_pong_game_ctrl;

    localparam int BB = 40, BS = 1, BM = 12, PB = 30, PS = 1, NL = 3, SF = 4;
`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic clk, rst, start_n, frame_start, ball_hit, ball_miss;
    logic ball_tick, paddle_tick, ball_reset;
    logic [7:0] score;
    logic [1:0] lives, game_state;

    pong_game_ctrl #(
        .BALL_BASE(BB), .BALL_STEP(BS), .BALL_MIN(BM),
        .PADDLE_BASE(PB), .PADDLE_STEP(PS), .LIVES(NL), .SERVE_FRAMES(SF)
    ) dut (
        .CLK_50(clk), .RESET(rst), .start_n(start_n), .frame_start(frame_start),
        .ball_hit(ball_hit), .ball_miss(ball_miss), .ball_tick(ball_tick),
        .paddle_tick(paddle_tick), .ball_reset(ball_reset), .score(score),
        .lives(lives), .game_state(game_state)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    bit chk_en = 0;
    int cyc_n = 0;

    // Reference model state (game rules in plain integers)
    int m_state, m_score, m_lives, m_frames;
    bit m_paused;
    bit m_h1, m_h2, m_h3;
    int m_bcnt, m_bper, m_pcnt, m_pper;
    bit e_btick, e_ptick, e_breset;

    function automatic int ball_period(input int s);
        int v;
        v = BB - BS * s;
        return (v < BM) ? BM : v;
    endfunction

    function automatic int paddle_period(input int s);
        return PB + PS * s;
    endfunction

    task automatic model_step(input bit r, input bit sn, input bit fs, input bit hit, input bit miss);
        bit press, frozen, brun, prun, was_act, is_act;
        int old_state, old_score;
        bit old_paused;
        if (r) begin
            m_state = 0; m_score = 0; m_lives = 0; m_frames = 0; m_paused = 0;
            m_h1 = 0; m_h2 = 0; m_h3 = 0;
            m_bcnt = 0; m_pcnt = 0; m_bper = ball_period(0); m_pper = paddle_period(0);
            e_btick = 0; e_ptick = 0; e_breset = 1;
            return;
        end
        press = m_h3 && !m_h2;
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = sn;
        old_state = m_state; old_score = m_score; old_paused = m_paused;
        if (m_state == 0 || m_state == 3) begin
            if (press) begin m_state = 1; m_score = 0; m_lives = NL; m_frames = 0; end
        end else if (m_state == 1) begin
            if (fs) begin
                m_frames++;
                if (m_frames == SF) begin m_state = 2; m_frames = 0; end
            end
        end else begin
            if (PAUSE_EN && press) m_paused = !m_paused;
            else if (!m_paused) begin
                if (miss) begin
                    m_lives--;
                    m_state = (m_lives == 0) ? 3 : 1;
                    m_frames = 0;
                end else if (hit && m_score < 255) m_score++;
            end
        end
        frozen = PAUSE_EN && (old_paused || m_paused);
        brun = (old_state == 2) && (m_state == 2) && !frozen;
        was_act = (old_state == 1 || old_state == 2);
        is_act = (m_state == 1 || m_state == 2);
        prun = was_act && is_act && !frozen;
        if (m_state != 2) begin m_bcnt = 0; m_bper = ball_period(old_score); end
        else if (brun) begin
            m_bcnt++;
            if (m_bcnt == m_bper) begin m_bcnt = 0; m_bper = ball_period(old_score); end
        end
        if (!is_act) begin m_pcnt = 0; m_pper = paddle_period(old_score); end
        else if (prun) begin
            m_pcnt++;
            if (m_pcnt == m_pper) begin m_pcnt = 0; m_pper = paddle_period(old_score); end
        end
        e_btick = brun && (m_bcnt == m_bper - 1);
        e_ptick = prun && (m_pcnt == m_pper - 1);
        e_breset = (m_state != 2);
    endtask

    // Per-cycle compare of every output against the model
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            n_vec++;
            if (game_state != 2'(m_state) || score != 8'(m_score) || lives != 2'(m_lives) ||
                ball_tick != e_btick || paddle_tick != e_ptick || ball_reset != e_breset) begin
                n_err++;
                $display("FAIL model cyc=%0d got st=%0d sc=%0d lv=%0d bt=%0b pt=%0b br=%0b exp st=%0d sc=%0d lv=%0d bt=%0b pt=%0b br=%0b",
                         cyc_n, game_state, score, lives, ball_tick, paddle_tick, ball_reset,
                         m_state, m_score, m_lives, e_btick, e_ptick, e_breset);
            end
        end
    end

    task automatic cyc(input bit r, input bit sn, input bit fs, input bit hit, input bit miss);
        @(negedge clk);
        rst = r; start_n = sn; frame_start = fs; ball_hit = hit; ball_miss = miss;
        model_step(r, sn, fs, hit, miss);
        cyc_n++;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic press();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
    endtask

    task automatic to_play();
        for (int i = 0; i < 60 && game_state != 2'd2; i++) cyc(0, 1, i % 2, 0, 0);
        chk("to_play", game_state, 2);
    endtask

    // Measure tick spacing of the ball (sel=0) or paddle (sel=1) over n idle cycles
    task automatic measure(input string name, input bit sel, input int n, input int exp_per);
        int last, prev_t, seen;
        bit t;
        last = -1; prev_t = 0; seen = 0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0);
            t = sel ? paddle_tick : ball_tick;
            if (t && prev_t) chk({name, "_width"}, 2, 1);
            if (t) begin
                if (last >= 0) chk(name, i - last, exp_per);
                last = i; seen++;
            end
            prev_t = t;
        end
        if (seen < 2) chk({name, "_seen"}, seen, 2);
    endtask

    initial begin
        int quiet;
        bit sn_lvl;
        clk = 0; rst = 1; start_n = 1; frame_start = 0; ball_hit = 0; ball_miss = 0;

        cyc(1, 1, 0, 0, 0);
        chk_en = 1;
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("rst_state", game_state, 0);
        chk("rst_lives", lives, 0);
        chk("rst_breset", ball_reset, 1);
        idle(5);

        press();
        chk("start_state", game_state, 1);
        chk("start_lives", lives, 3);
        chk("start_score", score, 0);
        chk("serve_breset", ball_reset, 1);
        to_play();
        chk("play_breset", ball_reset, 0);

        measure("ball_per0", 0, 130, 40);
        measure("pad_per0", 1, 100, 30);

        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0);
        chk("score5", score, 5);
        cyc(0, 1, 0, 1, 1);
        chk("hitmiss_score", score, 5);
        chk("hitmiss_lives", lives, 2);
        chk("hitmiss_state", game_state, 1);

        to_play();
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 1, 0);
        chk("score_sat", score, 255);
        cyc(0, 1, 0, 1, 0);
        chk("score_sat2", score, 255);
        measure("ball_floor", 0, 60, 12);

        for (int i = 0; i < 6 && game_state != 2'd3; i++) begin
            cyc(0, 1, 0, 0, 1);
            if (game_state == 2'd1) to_play();
        end
        chk("over_state", game_state, 3);
        chk("over_score", score, 255);
        quiet = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(0, 1, 0, 0, 0);
            quiet += int'(ball_tick);
        end
        chk("over_silent", quiet, 0);
        press();
        chk("restart_state", game_state, 1);
        chk("restart_score", score, 0);
        chk("restart_lives", lives, 3);

        to_play();
        press();
        chk("play_press_state", game_state, 2);
`ifdef PONG_PAUSE_EN
        quiet = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(0, 1, 0, 1, i == 100);
            quiet += int'(ball_tick) + int'(paddle_tick);
        end
        chk("pause_silent", quiet, 0);
        chk("pause_score", score, 0);
        chk("pause_lives", lives, 3);
        press();
        quiet = 0;
        for (int i = 0; i < 60 && quiet == 0; i++) begin
            cyc(0, 1, 0, 0, 0);
            quiet += int'(ball_tick);
        end
        chk("resume_tick", quiet, 1);
`endif

        for (int i = 0; i < 17; i++) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("midrst_state", game_state, 0);
        cyc(0, 1, 0, 0, 0);
        chk("midrst_btick", ball_tick, 0);
        chk("midrst_ptick", paddle_tick, 0);

        sn_lvl = 1;
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 24) == 0) sn_lvl = !sn_lvl;
            cyc($urandom_range(0, 2999) == 0, sn_lvl, $urandom_range(0, 2) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0);
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
